// File: rtl/if1_fetch_unit_pkg.sv
// if1_fetch_unit_pkg: shared datapath width, reset fetch address and IF1 FSM encoding.
package if1_fetch_unit_pkg;

    localparam int WORD = 32;
    localparam logic [WORD-1:0] PC_RST_DEFAULT = 32'h1c00_0000;

    typedef enum logic [1:0] {
        IF1_IDLE = 2'd0,
        IF1_WAIT = 2'd1,
        IF1_DROP = 2'd2
    } if1_state_e;

endpackage

// File: rtl/if1_fetch_unit_hold_buf.sv
// if1_hold_buf: single-entry PC/instruction skid buffer for responses that arrive while IF1/ID is stalled.
module if1_hold_buf
    import if1_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_i,
    input  logic            release_i,
    input  logic            clear_i,
    input  logic [WORD-1:0] pc_i,
    input  logic [WORD-1:0] inst_i,
    output logic            valid_o,
    output logic [WORD-1:0] pc_o,
    output logic [WORD-1:0] inst_o
);

    logic            valid_q;
    logic [WORD-1:0] pc_q, inst_q;

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= 1'b0;
        else if (clear_i | release_i)
            valid_q <= 1'b0;
        else if (capture_i)
            valid_q <= 1'b1;
        if (capture_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if1_fetch_unit.sv
// if1_fetch_unit: IF1 fetch stage, one outstanding ICache request plus one held instruction.
// Define IF1_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
module if1_fetch_unit
    import if1_fetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] PC_RST = PC_RST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF1_stall_from_DCache,
    input  logic            IF1_stall_from_Load,
    input  logic            IF1_flush_from_EX_Branch,
    input  logic [WORD-1:0] IF1_branch_target,
    output logic            icache_req_valid,
    output logic [WORD-1:0] icache_req_addr,
    input  logic            icache_req_ready,
    input  logic            icache_resp_valid,
    input  logic [WORD-1:0] icache_resp_inst,
    output logic [WORD-1:0] IF1_PC_out,
    output logic [WORD-1:0] IF1_inst_out,
    output logic            IF1_flush_to_IF1_ID
`ifdef IF1_PERF_CNT_EN
    ,
    output logic [WORD-1:0] perf_fetch_cnt,
    output logic [WORD-1:0] perf_bubble_cnt
`endif
);

    if1_state_e      state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d, out_pc_q, out_pc_d;
    logic            stall, redirect, acc, resp_ok, rel, deliver;
    logic            hold_valid;
    logic [WORD-1:0] hold_pc, hold_inst;

    assign redirect = IF1_flush_from_EX_Branch;
    assign stall    = IF1_stall_from_DCache | (~redirect & IF1_stall_from_Load);

    if1_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .capture_i(resp_ok & stall),
        .release_i(rel),
        .clear_i  (redirect),
        .pc_i     (out_pc_q),
        .inst_i   (icache_resp_inst),
        .valid_o  (hold_valid),
        .pc_o     (hold_pc),
        .inst_o   (hold_inst)
    );

    always_comb begin
        icache_req_valid    = ~rst & (state_q == IF1_IDLE) & ~hold_valid & ~redirect;
        icache_req_addr     = pc_q;
        acc                 = icache_req_valid & icache_req_ready;
        resp_ok             = (state_q == IF1_WAIT) & icache_resp_valid & ~redirect;
        rel                 = hold_valid & ~stall & ~redirect;
        deliver             = ~rst & (rel | (resp_ok & ~hold_valid & ~stall));
        IF1_PC_out          = deliver ? (rel ? hold_pc : out_pc_q) : '0;
        IF1_inst_out        = deliver ? (rel ? hold_inst : icache_resp_inst) : '0;
        IF1_flush_to_IF1_ID = ~deliver;
        pc_d                = redirect ? (IF1_branch_target & ~32'd3) : acc ? pc_q + 32'd4 : pc_q;
        out_pc_d            = acc ? pc_q : out_pc_q;
        // A response arriving in DROP is consumed even if a new redirect lands in the same cycle.
        state_d = (state_q == IF1_IDLE) ? (acc ? IF1_WAIT : IF1_IDLE)
                : (state_q == IF1_WAIT) ? (icache_resp_valid ? IF1_IDLE : redirect ? IF1_DROP : IF1_WAIT)
                : (icache_resp_valid ? IF1_IDLE : IF1_DROP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IF1_IDLE;
            pc_q     <= PC_RST;
            out_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
        end
    end

`ifdef IF1_PERF_CNT_EN
    logic [WORD-1:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {{(WORD-1){1'b0}}, deliver};
            bubble_cnt_q <= bubble_cnt_q + {{(WORD-1){1'b0}}, ~deliver & ~stall};
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if1_fetch_unit.sv
// tb_if1_fetch_unit: randomized stimulus against a program-order fetch model with a latency-modelled ICache.
module tb_if1_fetch_unit;
    import if1_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, dc_stall, ld_stall, br, ready, resp_valid;
    logic [31:0] tgt, resp_inst;
    logic        req_valid, flush;
    logic [31:0] req_addr, pc_out, inst_out;
`ifdef IF1_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_bubble;
    logic [31:0] m_fetch, m_bubble;
`endif

    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    if1_fetch_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .IF1_stall_from_DCache   (dc_stall),
        .IF1_stall_from_Load     (ld_stall),
        .IF1_flush_from_EX_Branch(br),
        .IF1_branch_target       (tgt),
        .icache_req_valid        (req_valid),
        .icache_req_addr         (req_addr),
        .icache_req_ready        (ready),
        .icache_resp_valid       (resp_valid),
        .icache_resp_inst        (resp_inst),
        .IF1_PC_out              (pc_out),
        .IF1_inst_out            (inst_out),
        .IF1_flush_to_IF1_ID     (flush)
`ifdef IF1_PERF_CNT_EN
        ,
        .perf_fetch_cnt          (perf_fetch),
        .perf_bubble_cnt         (perf_bubble)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    // Model: requests and deliveries both walk the program order from the reset PC or the latest
    // redirect target; "outstanding" is the ICache's view, "live" says whether that request is still wanted.
    logic [31:0] exp_req, exp_pc, out_addr;
    bit          outstanding, live, owed, just_reset, quiet, stall, resp_live, exp_rv, deliver;
    int          delay, lat;

    initial begin
        rst = 1'b1; dc_stall = 1'b0; ld_stall = 1'b0; br = 1'b0; tgt = '0;
        ready = 1'b0; resp_valid = 1'b0; resp_inst = '0;
        exp_req = PC_RST_DEFAULT; exp_pc = PC_RST_DEFAULT; out_addr = '0;
        outstanding = 0; live = 0; owed = 0; just_reset = 0; delay = 0; lat = 1;
`ifdef IF1_PERF_CNT_EN
        m_fetch = '0; m_bubble = '0;
`endif
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            quiet    = cyc < 30;
            rst      = cyc < 2 || (!quiet && $urandom_range(0, 99) == 0);
            dc_stall = !quiet && $urandom_range(0, 3) == 0;
            ld_stall = !quiet && $urandom_range(0, 4) == 0;
            br       = !quiet && $urandom_range(0, 9) == 0;
            tgt      = ($urandom_range(0, 3) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf)) : $urandom;
            ready    = quiet || $urandom_range(0, 3) != 0;
            lat      = quiet ? 1 : $urandom_range(1, 3);
            resp_valid = 1'b0;
            resp_inst  = $urandom;
            if (outstanding) begin
                if (delay == 1) begin
                    resp_valid = 1'b1;
                    resp_inst  = mem(out_addr);
                end else delay--;
            end else if (just_reset && $urandom_range(0, 1) == 1) resp_valid = 1'b1;
            @(negedge clk);
            stall     = dc_stall | (~br & ld_stall);
            resp_live = resp_valid & outstanding & live & ~br;
            exp_rv    = !rst && !br && !outstanding && !owed;
            deliver   = !rst && !br && !stall && (owed || resp_live);
            chk("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("req_addr", req_addr, exp_req);
            chk("flush", {31'd0, flush}, {31'd0, !deliver});
            if (deliver) begin
                chk("pc", pc_out, exp_pc);
                chk("inst", inst_out, mem(exp_pc));
            end else begin
                chk("bubble_pc", pc_out, 32'd0);
                chk("bubble_inst", inst_out, 32'd0);
            end
`ifdef IF1_PERF_CNT_EN
            chk("perf_fetch", perf_fetch, m_fetch);
            chk("perf_bubble", perf_bubble, m_bubble);
            m_fetch  = rst ? 32'd0 : m_fetch + (deliver ? 32'd1 : 32'd0);
            m_bubble = rst ? 32'd0 : m_bubble + ((!deliver && !stall) ? 32'd1 : 32'd0);
`endif
            if (rst) begin
                exp_req = PC_RST_DEFAULT; exp_pc = PC_RST_DEFAULT;
                outstanding = 0; live = 0; owed = 0; just_reset = 1;
            end else begin
                just_reset = 0;
                if (resp_valid && outstanding) outstanding = 0;
                if (deliver) begin
                    exp_pc = exp_pc + 32'd4;
                    owed   = 0;
                end else if (resp_live && stall) owed = 1;
                if (br) begin
                    exp_req = tgt & 32'hffff_fffc;
                    exp_pc  = tgt & 32'hffff_fffc;
                    live = 0; owed = 0;
                end
                if (exp_rv && ready) begin
                    outstanding = 1; live = 1; out_addr = exp_req; delay = lat;
                    exp_req = exp_req + 32'd4;
                end
            end
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
